// File: rtl/multicycle_control_fsm_if.sv
// Controller <-> datapath/memory bundle for the multicycle RV32I core.
// master: controller (decode fields, Zero, MemReady in; controls out); slave: datapath.
interface multicycle_control_fsm_if #(
   parameter int STATE_W = 4
);
   logic [6:0]         op;
   logic [2:0]         funct3;
   logic               funct7b5;
   logic               Zero;
   logic               MemReady;
   logic               PCWrite;
   logic               AdrSrc;
   logic               MemWrite;
   logic               IRWrite;
   logic               RegWrite;
   logic [1:0]         ResultSrc;
   logic [1:0]         ALUSrcA;
   logic [1:0]         ALUSrcB;
   logic [2:0]         ALUControl;
   logic [1:0]         ImmSrc;
   logic               IllegalInstr;
   logic [STATE_W-1:0] StateOut;

   modport master (
      input  op, funct3, funct7b5, Zero, MemReady,
      output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
      output ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc,
      output IllegalInstr, StateOut
   );

   modport slave (
      output op, funct3, funct7b5, Zero, MemReady,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
      input  ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc,
      input  IllegalInstr, StateOut
   );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main multicycle RV32I controller: Moore FSM plus ALU and immediate decoders.
// Ports: clk, rst_n (async active-low), bus (multicycle_control_fsm_if.master).
// Option: define CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes in TRAP.
module multicycle_control_fsm #(
   parameter int STATE_W = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   multicycle_control_fsm_if.master bus
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   typedef enum logic [STATE_W-1:0] {
      FETCH,
      DECODE,
      MEMADR,
      MEMREAD,
      MEMWB,
      MEMWRITE,
      EXECUTER,
      EXECUTEI,
      ALUWB,
      BEQ,
      JAL
`ifdef CTRL_ILLEGAL_TRAP_EN
      , TRAP
`endif
   } state_t;

   state_t     state;
   state_t     next;
   logic       adrsrc;
   logic       memwrite;
   logic       irwrite;
   logic       regwrite;
   logic [1:0] resultsrc;
   logic [1:0] srca;
   logic [1:0] srcb;
   logic [1:0] aluop;
   logic       branch;
   logic       pcupdate;
   logic       illegal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FETCH;
      else        state <= next;
   end

   always_comb begin
      next      = FETCH;
      adrsrc    = 1'b0;
      memwrite  = 1'b0;
      irwrite   = 1'b0;
      regwrite  = 1'b0;
      resultsrc = 2'b00;
      srca      = 2'b00;
      srcb      = 2'b00;
      aluop     = 2'b00;
      branch    = 1'b0;
      pcupdate  = 1'b0;
      illegal   = 1'b0;
      unique case (state)
         FETCH: begin
            srcb      = 2'b10;
            resultsrc = 2'b10;
            irwrite   = bus.MemReady;
            pcupdate  = bus.MemReady;
            next      = bus.MemReady ? DECODE : FETCH;
         end
         DECODE: begin
            srca = 2'b01;
            srcb = 2'b10;
            unique case (bus.op)
               OP_LOAD, OP_STORE: next = MEMADR;
               OP_R:              next = EXECUTER;
               OP_I:              next = EXECUTEI;
               OP_BEQ:            next = BEQ;
               OP_JAL:            next = JAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
               default:           next = TRAP;
`else
               default:           next = FETCH;
`endif
            endcase
         end
         MEMADR: begin
            srca = 2'b10;
            srcb = 2'b01;
            next = bus.op[5] ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            adrsrc = 1'b1;
            next   = bus.MemReady ? MEMWB : MEMREAD;
         end
         MEMWB: begin
            resultsrc = 2'b01;
            regwrite  = 1'b1;
         end
         MEMWRITE: begin
            adrsrc   = 1'b1;
            memwrite = 1'b1;
            next     = bus.MemReady ? FETCH : MEMWRITE;
         end
         EXECUTER: begin
            srca  = 2'b10;
            aluop = 2'b10;
            next  = ALUWB;
         end
         EXECUTEI: begin
            srca  = 2'b10;
            srcb  = 2'b01;
            aluop = 2'b10;
            next  = ALUWB;
         end
         ALUWB: regwrite = 1'b1;
         BEQ: begin
            srca   = 2'b10;
            aluop  = 2'b01;
            branch = 1'b1;
         end
         JAL: begin
            srca     = 2'b01;
            srcb     = 2'b10;
            pcupdate = 1'b1;
            next     = ALUWB;
         end
`ifdef CTRL_ILLEGAL_TRAP_EN
         TRAP: begin
            illegal = 1'b1;
            next    = TRAP;
         end
`endif
         default: next = FETCH;
      endcase
   end

   // ALU decoder; sub on funct3=000 only for R-type with funct7b5 set
   always_comb begin
      bus.ALUControl = 3'b000;
      unique case (aluop)
         2'b01: bus.ALUControl = 3'b001;
         2'b10: begin
            unique case (bus.funct3)
               3'b000:  bus.ALUControl =
                          (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
               3'b010:  bus.ALUControl = 3'b101;
               3'b110:  bus.ALUControl = 3'b011;
               3'b111:  bus.ALUControl = 3'b010;
               default: bus.ALUControl = 3'b000;
            endcase
         end
         default: bus.ALUControl = 3'b000;
      endcase
   end

   always_comb begin
      bus.ImmSrc = 2'b00;
      unique case (bus.op)
         OP_STORE: bus.ImmSrc = 2'b01;
         OP_BEQ:   bus.ImmSrc = 2'b10;
         OP_JAL:   bus.ImmSrc = 2'b11;
         default:  bus.ImmSrc = 2'b00;
      endcase
   end

   // strobes are masked while reset is held so MemReady cannot leak through
   assign bus.PCWrite      = rst_n & (pcupdate | (branch & bus.Zero));
   assign bus.IRWrite      = rst_n & irwrite;
   assign bus.RegWrite     = rst_n & regwrite;
   assign bus.MemWrite     = rst_n & memwrite;
   assign bus.IllegalInstr = rst_n & illegal;
   assign bus.AdrSrc       = adrsrc;
   assign bus.ResultSrc    = resultsrc;
   assign bus.ALUSrcA      = srca;
   assign bus.ALUSrcB      = srcb;
   assign bus.StateOut     = state;

endmodule
